icache_tag_assoc: RTL

ICACHE_TAG_ASSOC -- requirements
Module: icache_tag_assoc

---
 rtl/icache_tag_assoc_if.sv | 36 +++
 rtl/icache_tag_assoc.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/icache_tag_assoc_if.sv
// Lookup, fill and flush signal bundle for the instruction-cache tag array.
// The master drives requests; the slave (the tag array) returns hit and fill-way results.
interface icache_tag_assoc_if #(
   parameter int IDX  = 6,
   parameter int TAG  = 9,
   parameter int WAYS = 4,
   parameter int WW   = $clog2(WAYS)
);
   logic [IDX-1:0] index;
   logic [TAG-1:0] tag_in;
   logic [IDX-1:0] index_missalign;
   logic [TAG-1:0] tag_missalign;
   logic           lookup_en;
   logic           fill_en;
   logic [IDX-1:0] fill_index;
   logic [TAG-1:0] fill_tag;
   logic           flush_req;
   logic           hit;
   logic [WW-1:0]  hit_way;
   logic           hit_missalign;
   logic [WW-1:0]  hit_way_missalign;
   logic [WW-1:0]  fill_way;
   logic           busy;

   modport master (
      output index, tag_in, index_missalign, tag_missalign,
      output lookup_en, fill_en, fill_index, fill_tag, flush_req,
      input  hit, hit_way, hit_missalign, hit_way_missalign, fill_way, busy
   );

   modport slave (
      input  index, tag_in, index_missalign, tag_missalign,
      input  lookup_en, fill_en, fill_index, fill_tag, flush_req,
      output hit, hit_way, hit_missalign, hit_way_missalign, fill_way, busy
   );
endinterface

// File: rtl/icache_tag_assoc.sv
// Set-associative instruction-cache tag array with tree PLRU replacement, a second
// lookup port for misaligned fetches, and a one-set-per-cycle invalidation sweep.
module icache_tag_assoc #(
   parameter int IDX  = 6,
   parameter int TAG  = 9,
   parameter int WAYS = 4,
   parameter int WW   = $clog2(WAYS)
) (
   input  logic               clk,
   input  logic               rst,
   icache_tag_assoc_if.slave  bus
);
   localparam int SETS = 2 ** IDX;
   localparam int PB   = WAYS - 1;

   typedef enum logic {IDLE, FLUSH} state_t;

   state_t         state_q, state_d;
   logic [IDX-1:0] cnt_q, cnt_d;

   logic [TAG-1:0]  tag_q   [SETS][WAYS];
   logic [WAYS-1:0] valid_q [SETS];
   logic [PB-1:0]   plru_q  [SETS];

   logic            busy;
   logic [WAYS-1:0] match_p, match_m, match_f;
   logic [WAYS-1:0] fill_valid;
   logic            hit_p, hit_m;
   logic [WW-1:0]   hit_way_p, hit_way_m, fill_way;
   logic            fill_do, lookup_upd;

   // Lowest set bit of a way vector; 0 when no bit is set.
   function automatic logic [WW-1:0] lowest(input logic [WAYS-1:0] v);
      logic [WW-1:0] r;
      r = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (v[w]) r = WW'(w);
      end
      return r;
   endfunction

   // Both geometries are handled on a 3-bit view so the 2-way case never indexes past its bit.
   function automatic logic [WW-1:0] plru_victim(input logic [PB-1:0] p);
      logic [2:0] b;
      logic [1:0] v;
      b = 3'(p);
      if (WAYS == 2) v = {1'b0, b[0]};
      else           v = b[0] ? {1'b1, b[2]} : {1'b0, b[1]};
      return v[WW-1:0];
   endfunction

   function automatic logic [PB-1:0] plru_touch(input logic [PB-1:0] p, input logic [WW-1:0] w);
      logic [2:0] b;
      logic [1:0] w2;
      b  = 3'(p);
      w2 = 2'(w);
      if (WAYS == 2) begin
         b[0] = ~w2[0];
      end else if (!w2[1]) begin
         b[0] = 1'b1;
         b[1] = ~w2[0];
      end else begin
         b[0] = 1'b0;
         b[2] = ~w2[0];
      end
      return b[PB-1:0];
   endfunction

   assign busy = (state_q == FLUSH);

   // Match vectors are gated with busy so stale valid bits never leak out mid-sweep.
   generate
      for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
         assign match_p[gi] = !busy && valid_q[bus.index][gi]
                              && (tag_q[bus.index][gi] == bus.tag_in);
         assign match_m[gi] = !busy && valid_q[bus.index_missalign][gi]
                              && (tag_q[bus.index_missalign][gi] == bus.tag_missalign);
         assign match_f[gi] = valid_q[bus.fill_index][gi]
                              && (tag_q[bus.fill_index][gi] == bus.fill_tag);
         assign fill_valid[gi] = valid_q[bus.fill_index][gi];
      end
   endgenerate

   assign hit_p     = |match_p;
   assign hit_m     = |match_m;
   assign hit_way_p = lowest(match_p);
   assign hit_way_m = lowest(match_m);

   always_comb begin
      fill_way = plru_victim(plru_q[bus.fill_index]);
      if (|match_f)          fill_way = lowest(match_f);
      else if (~&fill_valid) fill_way = lowest(~fill_valid);
   end

   // A flush request in IDLE wins over a fill presented in the same cycle.
   assign fill_do    = bus.fill_en && (state_q == IDLE) && !bus.flush_req;
   assign lookup_upd = bus.lookup_en && hit_p;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (bus.flush_req) begin
               state_d = FLUSH;
               cnt_d   = '0;
            end
         end
         FLUSH: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == IDX'(SETS - 1)) state_d = IDLE;
         end
         default: begin
            state_d = FLUSH;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FLUSH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Tags, valid and PLRU bits are not reset; the sweep invalidates every set instead.
   always_ff @(posedge clk) begin
      if (busy) begin
         valid_q[cnt_q] <= '0;
         plru_q[cnt_q]  <= '0;
      end else begin
         if (lookup_upd) begin
            plru_q[bus.index] <= plru_touch(plru_q[bus.index], hit_way_p);
         end
         // Issued after the hit update so the fill's PLRU write wins on a shared set.
         if (fill_do) begin
            tag_q[bus.fill_index][fill_way]   <= bus.fill_tag;
            valid_q[bus.fill_index][fill_way] <= 1'b1;
            plru_q[bus.fill_index]            <= plru_touch(plru_q[bus.fill_index], fill_way);
         end
      end
   end

   assign bus.hit               = hit_p;
   assign bus.hit_way           = hit_way_p;
   assign bus.hit_missalign     = hit_m;
   assign bus.hit_way_missalign = hit_way_m;
   assign bus.fill_way          = fill_way;
   assign bus.busy              = busy;
endmodule
